seq_equality_comparator: RTL and testbench

//   Parametrised multi-cycle equality comparator for WIDTH-bit operands.
//   - Captures A/B on START, then compares one CHUNK-bit slice per clock, LSB slice first.
//   - Reports equal/not-equal and the index of the first mismatching slice, with a START/BUSY/DONE handshake.
//   - Replaces the fixed 2-bit combinational comparator wherever operands are wide and a small per-cycle compare is preferred.

---
 rtl/seq_equality_comparator.sv | 163 ++++++++++++++++
 tb/tb_seq_equality_comparator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_equality_comparator.sv
// seq_equality_comparator
//   Multi-cycle equality comparator for WIDTH-bit operands. A and B are
//   captured on an accepted START, then compared one CHUNK-bit slice per
//   clock, lowest slice first. The result (EQ, index of the lowest
//   mismatching slice) is registered on entry to FIN, where DONE pulses.
//
//   Optional build macro: EQ_CMP_EARLY_EXIT_EN
//     defined   -> the compare ends on the first mismatching slice
//     undefined -> all slices are always compared (fixed latency)
//   The reported EQ / MISMATCH_IDX are identical in both builds.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for START; last result held on EQ / MISMATCH_IDX
//   CMP   | comparing slice idx; BUSY=1; START ignored
//   FIN   | one cycle; DONE=1; START here begins the next compare at once

module seq_equality_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDXW  = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic             EQ,
    output logic [IDXW-1:0]  MISMATCH_IDX
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              eq_acc_q, eq_acc_d;
    logic [IDXW-1:0]   first_idx_q, first_idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              eq_q, eq_d;
    logic [IDXW-1:0]   mismatch_idx_q, mismatch_idx_d;

    logic [CHUNK-1:0]  slice_diff;
    logic              slice_eq;
    logic              first_miss;
    logic              eq_final;
    logic [IDXW-1:0]   idx_final;
    logic              cmp_last;

    // Select the XOR of the slice currently addressed by idx_q. Indices at or
    // beyond NCHUNK are unreachable because the compare stops at LAST_IDX.
    always_comb begin
        slice_diff = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                slice_diff = a_q[i*CHUNK +: CHUNK] ^ b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Per-slice compare outcome and the result that FIN would publish.
    always_comb begin
        slice_eq   = ~|slice_diff;
        first_miss = eq_acc_q & ~slice_eq;
        eq_final   = eq_acc_q & slice_eq;
        // The lowest mismatch wins: either this slice (first failure) or the
        // one already recorded by an earlier slice.
        idx_final  = first_miss ? idx_q : first_idx_q;
`ifdef EQ_CMP_EARLY_EXIT_EN
        cmp_last   = (idx_q == LAST_IDX) | first_miss;
`else
        cmp_last   = (idx_q == LAST_IDX);
`endif
    end

    // Next-state and datapath updates; every *_d defaults to hold.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        eq_acc_d       = eq_acc_q;
        first_idx_d    = first_idx_q;
        a_d            = a_q;
        b_d            = b_q;
        eq_d           = eq_q;
        mismatch_idx_d = mismatch_idx_q;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (START) begin
                    a_d         = A;
                    b_d         = B;
                    idx_d       = '0;
                    eq_acc_d    = 1'b1;
                    first_idx_d = '0;
                    state_d     = ST_CMP;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_CMP: begin
                if (first_miss) begin
                    eq_acc_d    = 1'b0;
                    first_idx_d = idx_q;
                end
                if (cmp_last) begin
                    // Results only change here, so they stay stable from one
                    // FIN until the next compare reaches its FIN.
                    eq_d           = eq_final;
                    mismatch_idx_d = eq_final ? '0 : idx_final;
                    state_d        = ST_FIN;
                end else begin
                    idx_d          = idx_q + IDXW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any compare in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            eq_acc_q       <= 1'b0;
            first_idx_q    <= '0;
            a_q            <= '0;
            b_q            <= '0;
            eq_q           <= 1'b0;
            mismatch_idx_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            eq_acc_q       <= eq_acc_d;
            first_idx_q    <= first_idx_d;
            a_q            <= a_d;
            b_q            <= b_d;
            eq_q           <= eq_d;
            mismatch_idx_q <= mismatch_idx_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        BUSY         = (state_q == ST_CMP);
        DONE         = (state_q == ST_FIN);
        EQ           = eq_q;
        MISMATCH_IDX = mismatch_idx_q;
    end

endmodule

// File: tb/tb_seq_equality_comparator.sv
// Bench for seq_equality_comparator (WIDTH=16, CHUNK=4, IDXW=2).
// Table-driven vectors plus hand-written sequences; expected results go into
// a scoreboard queue when START is driven and are checked when DONE pulses.

module tb_seq_equality_comparator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        BUSY;
    logic        DONE;
    logic        EQ;
    logic [1:0]  MISMATCH_IDX;

`ifdef EQ_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    seq_equality_comparator #(.WIDTH(16), .CHUNK(4), .IDXW(2)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .A            (A),
        .B            (B),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .EQ           (EQ),
        .MISMATCH_IDX (MISMATCH_IDX)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       eq;
        logic [1:0] idx;
        int         start_cyc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        eq;
        logic [1:0]  idx;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic eq, input logic [1:0] idx);
        if (EARLY && !eq) return int'(idx) + 1;
        return 4;
    endfunction

    // Scoreboard: every DONE pops one expectation and checks result and latency.
    always @(negedge CLK) begin
        if (!RESET && DONE) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("eq", int'(EQ), int'(mon_e.eq));
                chk("mismatch_idx", int'(MISMATCH_IDX), int'(mon_e.idx));
                chk("latency", cyc - mon_e.start_cyc, exp_lat(mon_e.eq, mon_e.idx));
            end
        end
    end

    // One START pulse, then scramble A/B to prove capture; waits for DONE.
    task automatic run_vec(input logic [15:0] va, input logic [15:0] vb,
                           input logic veq, input logic [1:0] vidx);
        int  busy_cnt;
        bit  seen;
        exp_t e;
        A = va;
        B = vb;
        START = 1'b1;
        e.eq = veq;
        e.idx = vidx;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (DONE) begin
                seen = 1'b1;
                break;
            end
            if (BUSY) busy_cnt++;
            @(negedge CLK);
        end
        chk("done_seen", int'(seen), 1);
        chk("busy_cycles", busy_cnt, exp_lat(veq, vidx));
        @(negedge CLK);
    endtask

    initial begin
        vecs[0] = '{16'hBEEF, 16'hBEEF, 1'b1, 2'd0};
        vecs[1] = '{16'h1234, 16'h1834, 1'b0, 2'd2};
        vecs[2] = '{16'h0001, 16'h8001, 1'b0, 2'd3};
        vecs[3] = '{16'hF00F, 16'h0FF0, 1'b0, 2'd0};
        vecs[4] = '{16'h5A5A, 16'h5A4A, 1'b0, 2'd1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 2'd0};
        vecs[6] = '{16'hFFFF, 16'hFFFE, 1'b0, 2'd0};

        // Reset state
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_eq", int'(EQ), 0);
        chk("rst_idx", int'(MISMATCH_IDX), 0);

        // Table vectors
        for (int v = 0; v < 7; v++) begin
            run_vec(vecs[v].a, vecs[v].b, vecs[v].eq, vecs[v].idx);
        end

        // START while BUSY is ignored; only the first compare completes.
        A = 16'h0000;
        B = 16'h0000;
        START = 1'b1;
        begin
            exp_t e;
            e.eq = 1'b1;
            e.idx = 2'd0;
            e.start_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge CLK);
        A = 16'hFFFF;
        B = 16'h0000;
        chk("busy_during_ignored_start", int'(BUSY), 1);
        repeat (3) @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        chk("ignored_start_sb_empty", sb.size(), 0);
        chk("ignored_start_eq_held", int'(EQ), 1);

        // Asynchronous reset between edges aborts a compare (EQ was 1 before).
        A = 16'h1111;
        B = 16'h1111;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("pre_rst_busy", int'(BUSY), 1);
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_busy", int'(BUSY), 0);
        chk("async_rst_done", int'(DONE), 0);
        chk("async_rst_eq", int'(EQ), 0);
        chk("async_rst_idx", int'(MISMATCH_IDX), 0);
        #1 RESET = 1'b0;
        repeat (8) @(negedge CLK);
        chk("post_rst_busy", int'(BUSY), 0);
        run_vec(16'h1234, 16'h1834, 1'b0, 2'd2);

        // START held high: accepted in every FIN, DONE every 5 cycles.
        A = 16'hCAFE;
        B = 16'hCAFE;
        START = 1'b1;
        begin
            int s;
            exp_t e;
            s = cyc + 1;
            for (int k = 0; k < 3; k++) begin
                e.eq = 1'b1;
                e.idx = 2'd0;
                e.start_cyc = s + 5 * k;
                sb.push_back(e);
            end
        end
        repeat (11) @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge CLK);
        end
        repeat (8) @(negedge CLK);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_idle", int'(BUSY), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
